score_bcd_display: RTL and testbench
====================================

Name: score_bcd_display

Overview:
- Parametrised successor to the single-digit score counter.
- Counts rising edges of REACHED_TARGET into an N-digit BCD score, with a configurable maximum and wrap or saturate mode.
- Time-multiplexes the score onto a common-anode 4-digit seven-segment display.
- Sits between the traffic-light game FSM, which raises REACHED_TARGET, and the board display pins.

Parameters:
- NUM_DIGITS, 4: BCD digits counted and displayed; legal 1..4.
- SCAN_DIV, 100000: CLK cycles per digit in the display scan; legal >= 2.
- MAX_SCORE, 9999: highest score value, in decimal; must be < 10**NUM_DIGITS.
- WRAP, 1: 1 = wrap from MAX_SCORE to 0; 0 = saturate at MAX_SCORE.

Ports:
- CLK, input, 1: system clock; all state changes on the rising edge.
- RESET, input, 1: asynchronous, active-high reset.
- REACHED_TARGET, input, 1: score event, synchronous to CLK; a rising edge scores one point.
- SCORE_CLR, input, 1: synchronous clear of the score.
- SEG_SELECT, output, 4: digit anodes, active-low; bit 0 is the rightmost digit.
- DEC_OUT, output, 8: segments, active-low; bit order {DP,g,f,e,d,c,b,a}.
- Score, output, 4*NUM_DIGITS: packed BCD score; digit 0 is in bits [3:0].
- ROLLOVER, output, 1: one-cycle pulse when the score wraps to 0.
- SATURATED, output, 1: high while WRAP=0 and Score==MAX_SCORE.

Behaviour:
- Reset (asynchronous, active-high):
  - Score=0, ROLLOVER=0, SATURATED=0.
  - Edge-detect register=0, scan counter=0, digit index=0.
  - SEG_SELECT=4'b1110, DEC_OUT=8'hC0 (digit "0", DP off).
- Edge detect:
  - prev_rt registers REACHED_TARGET each cycle.
  - inc = REACHED_TARGET & ~prev_rt.
  - Score updates on the same edge that sees inc, so it is visible 1 cycle after REACHED_TARGET is first sampled high.
  - A held-high level scores exactly once.
  - REACHED_TARGET high out of reset (prev_rt=0) scores one point.
- Score update priority, evaluated per edge:
  - 1. SCORE_CLR=1: Score<=0; inc ignored; ROLLOVER<=0.
  - 2. inc=1 and Score==MAX_SCORE, WRAP=1: Score<=0, ROLLOVER<=1 for exactly one cycle.
  - 3. inc=1 and Score==MAX_SCORE, WRAP=0: Score holds; no pulse.
  - 4. inc=1 otherwise: BCD increment with ripple carry; a digit at 9 goes to 0 and carries to the next.
  - 5. Else: Score holds; ROLLOVER<=0.
- Score never holds a non-BCD nibble. Comparison with MAX_SCORE uses its BCD encoding, computed at elaboration.
- SATURATED is combinational: (WRAP==0) && (Score==MAX_SCORE_BCD).
- Scan:
  - Scan counter counts 0..SCAN_DIV-1 and wraps.
  - When the counter wraps, digit index advances 0..NUM_DIGITS-1 and then back to 0.
  - Each digit is therefore lit for exactly SCAN_DIV cycles.
- Display decode (combinational from the registered digit index and Score):
  - SEG_SELECT drives bit [idx] low; all other bits high.
  - Bits >= NUM_DIGITS are always 1.
  - DEC_OUT = seven-segment pattern of the selected nibble; DP (bit 7) is always 1.
  - Patterns: 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90.
  - Any non-BCD nibble decodes to FF (blank).
- RESET asserted mid-scan or mid-count returns everything to the reset values immediately, without waiting for CLK.
- Simultaneous SCORE_CLR and REACHED_TARGET rising edge: the clear wins. prev_rt still updates, so no point is scored on the following cycle.

Optional Feature:
- Macro: SCORE_BLANK_LEADING_ZERO_EN.
- Defined:
  - Any digit above the most-significant nonzero digit of Score displays FF, with its anode still driven low.
  - Digit 0 always shows its value, so score 0 shows a single "0".
  - Example: NUM_DIGITS=4, Score=0x0042 gives digits 3 and 2 = FF, digit 1 = 99, digit 0 = A4.
- Undefined: all NUM_DIGITS digits display their value, including leading zeros.

Test Plan:
- Reset: RESET=1 for 60 ns, then release with REACHED_TARGET=0 -> Score=0, SEG_SELECT=1110, DEC_OUT=C0, ROLLOVER=0.
- Counting: SCAN_DIV=4; toggle REACHED_TARGET every 150 ns against a 100 ns CLK for 12 rising edges -> Score=0x0012. Then hold REACHED_TARGET high for 10 cycles -> Score stays 0x0012.
- Carry chain: preload to 0x0099 via 99 edges, then one more edge -> Score=0x0100, ROLLOVER=0. Scan then shows digit 2 = F9, digits 1 and 0 = C0.
- Wrap vs saturate:
  - MAX_SCORE=15, WRAP=1: 16th edge -> Score=0, ROLLOVER high for exactly 1 cycle.
  - WRAP=0: 16th and 17th edges -> Score=0x0015, SATURATED=1.
- Scan: SCAN_DIV=4, NUM_DIGITS=3 -> SEG_SELECT sequence 1110, 1101, 1011, 1110, each lasting 4 cycles; 0111 never appears.
- Clear and async reset:
  - SCORE_CLR on the same edge as a REACHED_TARGET rise -> Score=0 and no increment on the next cycle.
  - RESET pulsed between clock edges -> Score=0 and SEG_SELECT=1110 before the next CLK edge.

Source files
------------

// File: rtl/score_bcd_display.sv
// score_bcd_display: edge-triggered N-digit BCD score counter that time-multiplexes onto a
// common-anode 4-digit seven-segment display. Define SCORE_BLANK_LEADING_ZERO_EN to blank leading zeros.
`timescale 1ns/1ps
module score_bcd_display #(
   parameter int NUM_DIGITS = 4,
   parameter int SCAN_DIV   = 100000,
   parameter int MAX_SCORE  = 9999,
   parameter int WRAP       = 1
) (
   input  logic                    CLK,
   input  logic                    RESET,
   input  logic                    REACHED_TARGET,
   input  logic                    SCORE_CLR,
   output logic [3:0]              SEG_SELECT,
   output logic [7:0]              DEC_OUT,
   output logic [4*NUM_DIGITS-1:0] Score,
   output logic                    ROLLOVER,
   output logic                    SATURATED
);

   localparam int SW    = 4 * NUM_DIGITS;
   localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

   function automatic logic [SW-1:0] to_bcd(input int v);
      logic [SW-1:0] r;
      int            rem;
      r   = '0;
      rem = v;
      for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
         r[4*i +: 4] = 4'(rem % 10);
         rem         = rem / 10;
      end
      return r;
   endfunction

   localparam logic [SW-1:0] MAX_BCD = to_bcd(MAX_SCORE);

   logic              prev_rt;
   logic              inc;
   logic [SW-1:0]     score_inc;
   logic              carry;
   logic [CNT_W-1:0]  scan_cnt;
   logic [1:0]        digit_idx;
   logic [15:0]       score_pad;
   logic [3:0]        nibble;
   logic              show_blank;

   assign inc = REACHED_TARGET & ~prev_rt;

   // Ripple BCD increment: a 9 rolls to 0 and passes the carry upward.
   always_comb begin
      score_inc = Score;
      carry     = 1'b1;
      for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
         if (carry) begin
            if (Score[4*i +: 4] >= 4'd9) begin
               score_inc[4*i +: 4] = 4'd0;
            end else begin
               score_inc[4*i +: 4] = Score[4*i +: 4] + 4'd1;
               carry               = 1'b0;
            end
         end
      end
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         prev_rt  <= 1'b0;
         Score    <= '0;
         ROLLOVER <= 1'b0;
      end else begin
         prev_rt  <= REACHED_TARGET;
         ROLLOVER <= 1'b0;
         if (SCORE_CLR) begin
            Score <= '0;
         end else if (inc) begin
            if (Score == MAX_BCD) begin
               if (WRAP != 0) begin
                  Score    <= '0;
                  ROLLOVER <= 1'b1;
               end
            end else begin
               Score <= score_inc;
            end
         end
      end
   end

   always_comb begin
      SATURATED = (WRAP == 0) && (Score == MAX_BCD);
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         scan_cnt  <= '0;
         digit_idx <= '0;
      end else if (scan_cnt == CNT_W'(SCAN_DIV - 1)) begin
         scan_cnt  <= '0;
         digit_idx <= (digit_idx == 2'(NUM_DIGITS - 1)) ? 2'd0 : digit_idx + 2'd1;
      end else begin
         scan_cnt <= scan_cnt + CNT_W'(1);
      end
   end

   always_comb begin
      score_pad         = '0;
      score_pad[SW-1:0] = Score;
      nibble            = score_pad[{digit_idx, 2'b00} +: 4];
   end

`ifdef SCORE_BLANK_LEADING_ZERO_EN
   logic [3:0] lead_blank;
   logic       zero_above;

   // A digit blanks when it and every digit above it are zero; digit 0 never blanks.
   always_comb begin
      lead_blank = '0;
      zero_above = 1'b1;
      for (int unsigned i = 0; i < 3; i++) begin
         zero_above           = zero_above & (score_pad[4*(3-i) +: 4] == 4'd0);
         lead_blank[3-i]      = zero_above;
      end
      show_blank = lead_blank[digit_idx];
   end
`else
   always_comb begin
      show_blank = 1'b0;
   end
`endif

   always_comb begin
      SEG_SELECT            = '1;
      SEG_SELECT[digit_idx] = 1'b0;
      case (nibble)
         4'd0:    DEC_OUT = 8'hC0;
         4'd1:    DEC_OUT = 8'hF9;
         4'd2:    DEC_OUT = 8'hA4;
         4'd3:    DEC_OUT = 8'hB0;
         4'd4:    DEC_OUT = 8'h99;
         4'd5:    DEC_OUT = 8'h92;
         4'd6:    DEC_OUT = 8'h82;
         4'd7:    DEC_OUT = 8'hF8;
         4'd8:    DEC_OUT = 8'h80;
         4'd9:    DEC_OUT = 8'h90;
         default: DEC_OUT = 8'hFF;
      endcase
      if (show_blank) DEC_OUT = 8'hFF;
   end

endmodule

// File: tb/tb_score_bcd_display.sv
// Bench for score_bcd_display: four configurations share one stimulus stream and are checked
// every cycle against a decimal-arithmetic model, plus hand-computed spot values.
`timescale 1ns/1ps
module tb_score_bcd_display;

   localparam int SD = 4;
   localparam int ND [4] = '{4, 2, 2, 3};
   localparam int MX [4] = '{9999, 15, 15, 999};
   localparam int WR [4] = '{1, 1, 0, 1};

   logic CLK = 1'b0;
   logic RESET = 1'b0;
   logic REACHED_TARGET = 1'b0;
   logic SCORE_CLR = 1'b0;

   logic [15:0] sc0;
   logic [7:0]  sc1, sc2;
   logic [11:0] sc3;
   logic [15:0] a_sc [4];
   logic [3:0]  a_seg [4];
   logic [7:0]  a_dec [4];
   logic        a_roll [4];
   logic        a_sat [4];

   int total = 0;
   int bad   = 0;

   always #50 CLK = ~CLK;

   score_bcd_display #(.NUM_DIGITS(4), .SCAN_DIV(SD), .MAX_SCORE(9999), .WRAP(1)) u0 (
      .CLK(CLK), .RESET(RESET), .REACHED_TARGET(REACHED_TARGET), .SCORE_CLR(SCORE_CLR),
      .SEG_SELECT(a_seg[0]), .DEC_OUT(a_dec[0]), .Score(sc0), .ROLLOVER(a_roll[0]), .SATURATED(a_sat[0]));
   score_bcd_display #(.NUM_DIGITS(2), .SCAN_DIV(SD), .MAX_SCORE(15), .WRAP(1)) u1 (
      .CLK(CLK), .RESET(RESET), .REACHED_TARGET(REACHED_TARGET), .SCORE_CLR(SCORE_CLR),
      .SEG_SELECT(a_seg[1]), .DEC_OUT(a_dec[1]), .Score(sc1), .ROLLOVER(a_roll[1]), .SATURATED(a_sat[1]));
   score_bcd_display #(.NUM_DIGITS(2), .SCAN_DIV(SD), .MAX_SCORE(15), .WRAP(0)) u2 (
      .CLK(CLK), .RESET(RESET), .REACHED_TARGET(REACHED_TARGET), .SCORE_CLR(SCORE_CLR),
      .SEG_SELECT(a_seg[2]), .DEC_OUT(a_dec[2]), .Score(sc2), .ROLLOVER(a_roll[2]), .SATURATED(a_sat[2]));
   score_bcd_display #(.NUM_DIGITS(3), .SCAN_DIV(SD), .MAX_SCORE(999), .WRAP(1)) u3 (
      .CLK(CLK), .RESET(RESET), .REACHED_TARGET(REACHED_TARGET), .SCORE_CLR(SCORE_CLR),
      .SEG_SELECT(a_seg[3]), .DEC_OUT(a_dec[3]), .Score(sc3), .ROLLOVER(a_roll[3]), .SATURATED(a_sat[3]));

   always_comb begin
      a_sc[0] = sc0;
      a_sc[1] = 16'(sc1);
      a_sc[2] = 16'(sc2);
      a_sc[3] = 16'(sc3);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [15:0] exp_bcd(input int v);
      logic [15:0] r;
      int          x;
      x = v;
      for (int d = 0; d < 4; d++) begin
         r[4*d +: 4] = 4'(x % 10);
         x = x / 10;
      end
      return r;
   endfunction

   function automatic logic [7:0] seg_pat(input int d);
      case (d)
         0: return 8'hC0;
         1: return 8'hF9;
         2: return 8'hA4;
         3: return 8'hB0;
         4: return 8'h99;
         5: return 8'h92;
         6: return 8'h82;
         7: return 8'hF8;
         8: return 8'h80;
         9: return 8'h90;
         default: return 8'hFF;
      endcase
   endfunction

   // Model: plain decimal score per configuration, cycle count since reset for the scan.
   int  m_score [4] = '{0, 0, 0, 0};
   bit  m_roll  [4] = '{0, 0, 0, 0};
   int  m_cyc  = 0;
   bit  m_prev = 1'b0;
   logic m_inc;
   assign m_inc = REACHED_TARGET & ~m_prev;

   always @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         m_prev <= 1'b0;
         m_cyc  <= 0;
         for (int i = 0; i < 4; i++) begin
            m_score[i] <= 0;
            m_roll[i]  <= 1'b0;
         end
      end else begin
         m_prev <= REACHED_TARGET;
         m_cyc  <= m_cyc + 1;
         for (int i = 0; i < 4; i++) begin
            if (SCORE_CLR)
               m_score[i] <= 0;
            else if (m_inc)
               m_score[i] <= (m_score[i] == MX[i]) ? ((WR[i] == 1) ? 0 : MX[i]) : m_score[i] + 1;
            m_roll[i] <= !SCORE_CLR && m_inc && (m_score[i] == MX[i]) && (WR[i] == 1);
         end
      end
   end

   always @(negedge CLK) begin
      if (RESET === 1'b0) begin
         for (int i = 0; i < 4; i++) begin
            int idx;
            int dv;
            logic [7:0] ed;
            idx = (m_cyc / SD) % ND[i];
            dv  = (m_score[i] / (10 ** idx)) % 10;
            ed  = seg_pat(dv);
`ifdef SCORE_BLANK_LEADING_ZERO_EN
            if (idx > 0 && m_score[i] < 10 ** idx) ed = 8'hFF;
`endif
            chk($sformatf("u%0d.score", i), 32'(a_sc[i]), 32'(exp_bcd(m_score[i])));
            chk($sformatf("u%0d.seg_select", i), 32'(a_seg[i]), 32'(4'hF & ~(4'b0001 << idx)));
            chk($sformatf("u%0d.dec_out", i), 32'(a_dec[i]), 32'(ed));
            chk($sformatf("u%0d.rollover", i), 32'(a_roll[i]), 32'(m_roll[i]));
            chk($sformatf("u%0d.saturated", i), 32'(a_sat[i]),
                32'((WR[i] == 0) && (m_score[i] == MX[i])));
         end
      end
   end

   task automatic pulse();
      @(posedge CLK); #10 REACHED_TARGET = 1'b1;
      @(posedge CLK); #10 REACHED_TARGET = 1'b0;
   endtask

   task automatic clr();
      @(posedge CLK); #10 SCORE_CLR = 1'b1;
      @(posedge CLK); #10 SCORE_CLR = 1'b0;
   endtask

   task automatic see_digit(input logic [3:0] sel, input logic [7:0] exp, input string nm);
      bit found;
      found = 1'b0;
      for (int k = 0; k < 20 && !found; k++) begin
         @(negedge CLK);
         if (a_seg[0] == sel) begin
            found = 1'b1;
            chk(nm, 32'(a_dec[0]), 32'(exp));
         end
      end
      if (!found) begin
         total++;
         bad++;
         $display("FAIL %s: digit select %h never seen", nm, sel);
      end
   endtask

   logic [3:0] scan_exp [16] = '{4'hE, 4'hE, 4'hE, 4'hE, 4'hD, 4'hD, 4'hD, 4'hD,
                                 4'hB, 4'hB, 4'hB, 4'hB, 4'hE, 4'hE, 4'hE, 4'hE};

   initial begin
      RESET = 1'b1;
      #60 RESET = 1'b0;
      @(negedge CLK);
      chk("reset.score", 32'(sc0), 32'h0);
      chk("reset.seg_select", 32'(a_seg[0]), 32'hE);
      chk("reset.dec_out", 32'(a_dec[0]), 32'hC0);
      chk("reset.rollover", 32'(a_roll[0]), 32'h0);

      // 12 rising edges, the last one left high
      #10;
      repeat (23) begin
         REACHED_TARGET = ~REACHED_TARGET;
         #150;
      end
      chk("count.12", 32'(sc0), 32'h0012);
      repeat (10) @(posedge CLK);
      #10 chk("count.held", 32'(sc0), 32'h0012);
      REACHED_TARGET = 1'b0;

      clr();
      repeat (99) pulse();
      chk("carry.99", 32'(sc0), 32'h0099);
      pulse();
      chk("carry.100", 32'(sc0), 32'h0100);
      chk("carry.rollover", 32'(a_roll[0]), 32'h0);
      chk("carry.u3", 32'(sc3), 32'h100);
      see_digit(4'b1011, 8'hF9, "carry.digit2");
      see_digit(4'b1101, 8'hC0, "carry.digit1");
      see_digit(4'b1110, 8'hC0, "carry.digit0");

      clr();
      repeat (15) pulse();
      chk("wrap.15", 32'(sc1), 32'h15);
      chk("sat.15", 32'(sc2), 32'h15);
      chk("sat.flag15", 32'(a_sat[2]), 32'h1);
      pulse();
      chk("wrap.16", 32'(sc1), 32'h00);
      chk("sat.16", 32'(sc2), 32'h15);
      @(negedge CLK) chk("wrap.pulse_hi", 32'(a_roll[1]), 32'h1);
      @(negedge CLK) chk("wrap.pulse_lo", 32'(a_roll[1]), 32'h0);
      pulse();
      chk("wrap.17", 32'(sc1), 32'h01);
      chk("sat.17", 32'(sc2), 32'h15);
      chk("sat.flag17", 32'(a_sat[2]), 32'h1);
      chk("sat.no_pulse", 32'(a_roll[2]), 32'h0);

      // asynchronous reset between edges
      @(posedge CLK); #20 RESET = 1'b1;
      #5;
      chk("areset.score", 32'(sc0), 32'h0);
      chk("areset.seg", 32'(a_seg[0]), 32'hE);
      chk("areset.u3seg", 32'(a_seg[3]), 32'hE);
      #10 RESET = 1'b0;
      for (int k = 0; k < 16; k++) begin
         @(negedge CLK);
         chk($sformatf("scan.u3[%0d]", k), 32'(a_seg[3]), 32'(scan_exp[k]));
      end

      repeat (3) pulse();
      chk("clr.pre", 32'(sc0), 32'h0003);
      @(posedge CLK); #10;
      REACHED_TARGET = 1'b1;
      SCORE_CLR      = 1'b1;
      @(posedge CLK); #10 SCORE_CLR = 1'b0;
      chk("clr.wins", 32'(sc0), 32'h0);
      @(posedge CLK); #10 chk("clr.no_late_inc", 32'(sc0), 32'h0);
      repeat (2) @(posedge CLK);
      #10 REACHED_TARGET = 1'b0;

      repeat (3) @(posedge CLK);
      #10;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
